ibus_responder: RTL
===================

Name: ibus_responder

Overview:
Instruction-bus responder, the memory end of the ibus_req_t/ibus_resp_t protocol that the fetch stage drives. It accepts one fetch request at a time and returns one 32-bit instruction word after a fixed, configurable latency. The instruction words come from an internal word array that the bench preloads through a side port. It sits outside the riscv core, in the simulation top and in the verification bench, standing in for the instruction memory.

Parameters:
MEM_WORDS, 4096, number of 32-bit words in the array; power of two, at least 2.
BASE_ADDR, 64'h8000_0000, byte address of word 0.
LATENCY, 2, cycles from the addr_ok cycle to the data_ok cycle; at least 1.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
ireq  input  ibus_req_t  request from the core: valid (1), addr (64, byte address)
iresp  output  ibus_resp_t  response to the core: addr_ok (1), data_ok (1), data (32)
load_en  input  1  preload write strobe
load_idx  input  $clog2(MEM_WORDS)  preload word index
load_data  input  32  preload word
err  output  1  pulses together with data_ok when the request was misaligned or out of range

Behaviour:
- Reset (asynchronous, active-high; clock clk):
  - state goes to IDLE; counter = 0; latched data = 0.
  - addr_ok, data_ok, data and err are all 0 while rst is high and in the cycle after release.
  - Array contents are not reset.
- States and transitions:
  - IDLE: addr_ok = ireq.valid, combinational. If valid at the clock edge, the request is accepted: latch the response word and err, load counter = LATENCY-1, go to WAIT.
  - WAIT: addr_ok = 0. data_ok = (counter == 0), and data/err drive the latched values in that cycle. If counter == 0, go to IDLE; otherwise decrement.
- Timing: a request accepted at cycle N (addr_ok high at N) gets data_ok high at N+LATENCY, for exactly one cycle. The next request can be accepted at N+LATENCY+1. Peak throughput is one word per LATENCY+1 cycles. At most one request is outstanding.
- Handshake rules:
  - The requester holds valid and addr stable until addr_ok. After addr_ok, ireq is ignored until IDLE.
  - The responder never asserts data_ok without a prior accepted request.
  - data and err are 0 in every cycle where data_ok = 0.
- Address decode: off = addr - BASE_ADDR, 64-bit wrap-around subtraction.
  - If addr[1:0] != 0, the request is misaligned: response word 0, err = 1.
  - Else if off >= MEM_WORDS*4, the request is out of range, which includes addr < BASE_ADDR via the wrap: response word 0, err = 1.
  - Otherwise response word = mem[off[$clog2(MEM_WORDS)+1:2]], err = 0.
- The array is read at the acceptance edge. Later preloads do not change an in-flight response.
- Preload: if load_en is high at a clock edge, mem[load_idx] <= load_data. This is allowed in any state.
  - Preload to the word being accepted in the same edge: the accepted request returns the old value.
- ireq.valid dropping while in WAIT has no effect.
- Reset asserted while in WAIT: the outstanding response is discarded and data_ok never fires for it.
- LATENCY = 1: data_ok is in the cycle immediately after addr_ok.

Optional Feature:
IBUS_RAND_STALL_EN
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) with seed 16'hACE1 on reset advances every cycle.
  - In IDLE, addr_ok = ireq.valid & ~lfsr[0]. A request is accepted only when addr_ok is high.
  - Latency after acceptance is unchanged.
- Undefined: the LFSR is absent, and addr_ok is as specified above.

Test Plan:
1. Preload mem[0]=32'h00000513, mem[1]=32'h00100593; LATENCY=2; valid held at addr 0x8000_0000 -> addr_ok at cycle N, data_ok with data 32'h00000513 at N+2, err 0, next addr_ok at N+3.
2. Back-to-back requests at 0x8000_0000 then 0x8000_0004, valid held continuously -> data_ok at N+2 and N+5 with the two words, with no data_ok in the cycles between.
3. Request at 0x8000_0002 -> data_ok with data 0 and err 1. Request at 0x8000_4000 (MEM_WORDS=4096) -> data 0, err 1. Request at 0x7FFF_FFFC -> data 0, err 1.
4. Accept a request at idx 5 while load_en writes idx 5 in the same edge (old 32'h11111111, new 32'h22222222) -> response 32'h11111111. A following request at idx 5 -> 32'h22222222.
5. Assert rst one cycle after accepting a request -> no data_ok for that request; after release, all outputs 0 and a new request is accepted in IDLE; array contents are retained.
6. With IBUS_RAND_STALL_EN and valid held for 1000 cycles -> every addr_ok is followed by exactly one data_ok LATENCY cycles later; no protocol violation; at least one cycle has valid=1 and addr_ok=0.

Source files
------------

// File: rtl/ibus_pkg.sv
// Instruction-bus payload types shared by the fetch stage and the responder.
package ibus_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

endpackage

// File: rtl/ibus_responder.sv
// Instruction-bus responder: accepts one fetch at a time and returns a word
// from a preloadable array after a fixed latency.
// Optional build macro IBUS_RAND_STALL_EN: a free-running LFSR randomly
// withholds addr_ok in IDLE to stress the requester.
module ibus_responder
    import ibus_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  ibus_req_t                    ireq,
    output ibus_resp_t                   iresp,
    input  logic                         load_en,
    input  logic [$clog2(MEM_WORDS)-1:0] load_idx,
    input  logic [31:0]                  load_data,
    output logic                         err
);

    localparam int unsigned IDX_W    = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [63:0] SPAN     = 64'(MEM_WORDS) * 64'd4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_boot;
    logic [31:0]        r_data;
    logic               r_err;
    logic [31:0]        r_mem [MEM_WORDS];

    logic               w_addr_ok;
    logic               w_data_ok;
    logic               w_accept;
    logic               w_grant;
    logic [63:0]        w_off;
    logic [IDX_W-1:0]   w_idx;
    logic [31:0]        w_resp_data;
    logic               w_resp_err;

`ifdef IBUS_RAND_STALL_EN
    logic [15:0]        r_lfsr;
    logic               w_fb;

    assign w_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_grant = ~r_lfsr[0];

    // Free-running stall pattern generator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end
`else
    assign w_grant = 1'b1;
`endif

    assign w_off = ireq.addr - BASE_ADDR;
    assign w_idx = w_off[IDX_W+1:2];

    // Address decode and array read for the word about to be accepted.
    always_comb begin
        w_resp_data = 32'h0;
        w_resp_err  = 1'b0;
        if (ireq.addr[1:0] != 2'b00) begin
            w_resp_err = 1'b1;
        end else if (w_off >= SPAN) begin
            w_resp_err = 1'b1;
        end else begin
            w_resp_data = r_mem[w_idx];
        end
    end

    // State and counter registers; r_boot blanks the cycle after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_boot  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_boot  <= 1'b0;
        end
    end

    // Next-state, countdown and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_ok   = 1'b0;
        w_data_ok   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_addr_ok = ireq.valid & ~r_boot & w_grant;
                w_accept  = w_addr_ok;
                if (w_accept) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = CNT_INIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_data_ok   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Response word and error are captured at acceptance so later preloads cannot disturb them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= 32'h0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_data <= w_resp_data;
            r_err  <= w_resp_err;
        end
    end

    // Preload port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            r_mem[load_idx] <= load_data;
        end
    end

    assign iresp.addr_ok = w_addr_ok;
    assign iresp.data_ok = w_data_ok;
    assign iresp.data    = w_data_ok ? r_data : 32'h0;
    assign err           = w_data_ok & r_err;

endmodule
